// File: rtl/des_iter_core.sv
// rtl/des_iter_core.sv - iterative DES engine, one round per clock (two with DES_ROUND2_EN)
//
// Purpose : Runs a 64-bit block through 16 DES rounds on a shared round datapath.
//           On start in IDLE, it loads IP(din), PC-1(key), the round counter and the
//           direction. It then runs the rounds and registers FP(R16||L16) into dout
//           together with a one-cycle done pulse.
// Macro   : DES_ROUND2_EN - when defined, two rounds are chained per clock.
//           Results are identical in both builds; only the latency changes.
// Ports   : clk      rising-edge clock
//           rst      synchronous active-high reset
//           start    begin an operation (accepted only in IDLE)
//           decrypt  0 = encrypt, 1 = decrypt (sampled with start)
//           key      64-bit key, bit 1 = MSB (sampled with start)
//           din      64-bit input block, bit 1 = MSB (sampled with start)
//           busy     high while rounds execute
//           done     one-cycle pulse, dout valid in the same cycle
//           dout     result register, held until the next done
module des_iter_core (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        decrypt,
   input  logic [64:1] key,
   input  logic [64:1] din,
   output logic        busy,
   output logic        done,
   output logic [64:1] dout
);

`ifdef DES_ROUND2_EN
   localparam logic [4:0] RND_STEP = 5'd2;
   localparam logic [4:0] RND_LAST = 5'd15;
`else
   localparam logic [4:0] RND_STEP = 5'd1;
   localparam logic [4:0] RND_LAST = 5'd16;
`endif

   // Permutation tables list the 1-based source bit for each output bit, MSB first.
   localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
   localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
   localparam int E_T [48]  = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13,
                                12,13,14,15,16,17, 16,17,18,19,20,21,
                                20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
   localparam int P_T [32]  = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                                2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
   localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
   localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
                                 16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48,
                                 44,49,39,56,34,53, 46,42,50,36,29,32};

   // S-box contents des_s1..des_s8: 64 nibbles each, row-major (row 0 col 0 in the top nibble).
   localparam logic [255:0] S_T [8] = '{
      256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
      256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
      256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
      256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
      256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
      256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
      256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
      256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

   function automatic logic [63:0] perm_ip(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int k = 0; k < 64; k++) y[6'(63 - k)] = x[6'(64 - IP_T[k])];
      return y;
   endfunction

   function automatic logic [63:0] perm_fp(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int k = 0; k < 64; k++) y[6'(63 - k)] = x[6'(64 - FP_T[k])];
      return y;
   endfunction

   function automatic logic [47:0] perm_e(input logic [31:0] x);
      logic [47:0] y;
      y = '0;
      for (int k = 0; k < 48; k++) y[6'(47 - k)] = x[5'(32 - E_T[k])];
      return y;
   endfunction

   function automatic logic [31:0] perm_p(input logic [31:0] x);
      logic [31:0] y;
      y = '0;
      for (int k = 0; k < 32; k++) y[5'(31 - k)] = x[5'(32 - P_T[k])];
      return y;
   endfunction

   function automatic logic [55:0] perm_pc1(input logic [63:0] x);
      logic [55:0] y;
      y = '0;
      for (int k = 0; k < 56; k++) y[6'(55 - k)] = x[6'(64 - PC1_T[k])];
      return y;
   endfunction

   function automatic logic [47:0] perm_pc2(input logic [55:0] x);
      logic [47:0] y;
      y = '0;
      for (int k = 0; k < 48; k++) y[6'(47 - k)] = x[6'(56 - PC2_T[k])];
      return y;
   endfunction

   // b[5] is in[6] (lowest-numbered DES bit); outer bits select the row, inner four the column.
   function automatic logic [3:0] sbox(input logic [255:0] t, input logic [5:0] b);
      logic [5:0] idx;
      idx = {b[5], b[0], b[4:1]};
      return t[8'(255 - 4 * int'(idx)) -: 4];
   endfunction

   function automatic logic [31:0] f_fn(input logic [31:0] rh, input logic [47:0] k);
      logic [47:0] x;
      logic [31:0] s;
      x = perm_e(rh) ^ k;
      s = '0;
      for (int j = 0; j < 8; j++) s[5'(31 - 4 * j) -: 4] = sbox(S_T[j], x[6'(47 - 6 * j) -: 6]);
      return perm_p(s);
   endfunction

   // Encrypt rotates left before PC-2. Decrypt rotates right by the shift of the mirrored
   // encrypt round (none in round 1), so the 16 subkeys are visited in reverse order.
   function automatic logic [27:0] rot28(input logic [27:0] v, input logic dec, input logic [4:0] i);
      logic one;
      one = (i == 5'd1) || (i == 5'd2) || (i == 5'd9) || (i == 5'd16);
      if (!dec)
         return one ? {v[26:0], v[27]} : {v[25:0], v[27:26]};
      else if (i == 5'd1)
         return v;
      else
         return one ? {v[0], v[27:1]} : {v[1:0], v[27:2]};
   endfunction

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t      state;
   logic [31:0] l, r;
   logic [27:0] c, d;
   logic [4:0]  rnd;
   logic        dir;

   logic [27:0] c1, d1, nc, nd;
   logic [47:0] k1;
   logic [31:0] l1, r1, nl, nr;
`ifdef DES_ROUND2_EN
   logic [27:0] c2, d2;
   logic [47:0] k2;
`endif

   always_comb begin
      c1 = rot28(c, dir, rnd);
      d1 = rot28(d, dir, rnd);
      k1 = perm_pc2({c1, d1});
      l1 = r;
      r1 = l ^ f_fn(r, k1);
`ifdef DES_ROUND2_EN
      c2 = rot28(c1, dir, rnd + 5'd1);
      d2 = rot28(d1, dir, rnd + 5'd1);
      k2 = perm_pc2({c2, d2});
      nl = r1;
      nr = l1 ^ f_fn(r1, k2);
      nc = c2;
      nd = d2;
`else
      nl = l1;
      nr = r1;
      nc = c1;
      nd = d1;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         l     <= '0;
         r     <= '0;
         c     <= '0;
         d     <= '0;
         rnd   <= '0;
         dir   <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         dout  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  {l, r} <= perm_ip(din);
                  {c, d} <= perm_pc1(key);
                  rnd    <= 5'd1;
                  dir    <= decrypt;
                  busy   <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               if (rnd > 5'd16) begin
                  // unreachable counter value: abandon the operation
                  rnd   <= '0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  l <= nl;
                  r <= nr;
                  c <= nc;
                  d <= nd;
                  if (rnd == RND_LAST) begin
                     // result is formed from the final round output so it is visible in FIN
                     dout  <= perm_fp({nr, nl});
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= FIN;
                  end else begin
                     rnd <= rnd + RND_STEP;
                  end
               end
            end
            FIN: begin
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_des_iter_core.sv
// tb/tb_des_iter_core.sv - self-checking bench for des_iter_core with a DES reference model
module tb_des_iter_core;

`ifdef DES_ROUND2_EN
   localparam int LAT = 9;
`else
   localparam int LAT = 17;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        decrypt;
   logic [64:1] key;
   logic [64:1] din;
   logic        busy;
   logic        done;
   logic [64:1] dout;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   des_iter_core dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .decrypt (decrypt),
      .key     (key),
      .din     (din),
      .busy    (busy),
      .done    (done),
      .dout    (dout)
   );

   // ---------------- reference model (textbook DES, subkeys precomputed) ----------------
   int ip_q[$]  = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                    62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                    57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                    61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
   int p_q[$]   = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                    2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
   int pc1_q[$] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                    10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                    63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                    14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
   int pc2_q[$] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
                    16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48,
                    44,49,39,56,34,53, 46,42,50,36,29,32};
   logic [255:0] sb [8] = '{
      256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
      256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
      256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
      256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
      256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
      256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
      256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
      256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

   // src holds sw meaningful bits; DES bit n (1 = MSB) sits at shift sw-n.
   function automatic logic [63:0] perm(input logic [63:0] src, input int sw, input int tbl[$]);
      logic [63:0] o;
      o = '0;
      foreach (tbl[k]) o = (o << 1) | ((src >> (sw - tbl[k])) & 64'd1);
      return o;
   endfunction

   // Final permutation taken as the inverse of IP.
   function automatic logic [63:0] fp_ref(input logic [63:0] v);
      logic [63:0] o;
      o = '0;
      for (int pos = 1; pos <= 64; pos++)
         foreach (ip_q[j])
            if (ip_q[j] == pos) o = (o << 1) | ((v >> (64 - (j + 1))) & 64'd1);
      return o;
   endfunction

   function automatic logic [31:0] f_ref(input logic [31:0] rh, input logic [63:0] k);
      logic [63:0] e, x;
      logic [31:0] s;
      int src, six, row, col;
      e = '0;
      s = '0;
      for (int kk = 1; kk <= 48; kk++) begin
         src = ((4 * ((kk - 1) / 6) + (kk - 1) % 6 + 31) % 32) + 1;
         e = (e << 1) | 64'((rh >> (32 - src)) & 32'd1);
      end
      x = e ^ k;
      for (int j = 0; j < 8; j++) begin
         six = int'((x >> (42 - 6 * j)) & 64'd63);
         row = ((six >> 4) & 2) | (six & 1);
         col = (six >> 1) & 15;
         s = (s << 4) | (32'(sb[j] >> (4 * (63 - (row * 16 + col)))) & 32'hF);
      end
      return 32'(perm({32'd0, s}, 32, p_q));
   endfunction

   function automatic logic [63:0] des_ref(input logic [63:0] k64, input logic [63:0] blk, input bit dec);
      logic [63:0] ks [16];
      logic [63:0] cd, t;
      logic [27:0] c, d;
      logic [31:0] l, r, nr;
      int sh;
      cd = perm(k64, 64, pc1_q);
      c = cd[55:28];
      d = cd[27:0];
      for (int i = 0; i < 16; i++) begin
         sh = (i == 0 || i == 1 || i == 8 || i == 15) ? 1 : 2;
         for (int n = 0; n < sh; n++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
         end
         ks[i] = perm({8'd0, c, d}, 56, pc2_q);
      end
      t = perm(blk, 64, ip_q);
      l = t[63:32];
      r = t[31:0];
      for (int i = 0; i < 16; i++) begin
         nr = l ^ f_ref(r, ks[dec ? 15 - i : i]);
         l  = r;
         r  = nr;
      end
      return fp_ref({r, l});
   endfunction

   // ---------------- checking helpers ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Entered at a negedge (cycle 0); returns at the negedge of cycle LAT.
   task automatic run_op(input string tag, input logic [63:0] k, input logic [63:0] blk,
                         input bit dec, input logic [63:0] exp, input logic [63:0] prev,
                         input bit ghost);
      key = k;
      din = blk;
      decrypt = dec;
      start = 1'b1;
      for (int cy = 1; cy <= LAT; cy++) begin
         @(negedge clk);
         start   = 1'b0;
         key     = {$urandom, $urandom};
         din     = {$urandom, $urandom};
         decrypt = ~dec;
         if (ghost && (cy == 5 || cy == LAT)) begin
            start = 1'b1;
            din   = ~blk;
         end
         check($sformatf("%s busy c%0d", tag, cy), {63'd0, busy}, {63'd0, cy < LAT});
         check($sformatf("%s done c%0d", tag, cy), {63'd0, done}, {63'd0, cy == LAT});
         if (cy < LAT) check($sformatf("%s hold c%0d", tag, cy), dout, prev);
         else          check($sformatf("%s dout", tag), dout, exp);
      end
   endtask

   task automatic idle_check(input string tag, input int n, input logic [63:0] held);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         start = 1'b0;
         check($sformatf("%s idle busy %0d", tag, i), {63'd0, busy}, 64'd0);
         check($sformatf("%s idle done %0d", tag, i), {63'd0, done}, 64'd0);
         check($sformatf("%s idle dout %0d", tag, i), dout, held);
      end
   endtask

   localparam logic [63:0] KAT_K = 64'h133457799BBCDFF1;
   localparam logic [63:0] KAT_P = 64'h0123456789ABCDEF;
   localparam logic [63:0] KAT_C = 64'h85E813540F0AB405;
   localparam logic [63:0] WK_K  = 64'h0101010101010101;
   localparam logic [63:0] WK_P  = 64'h95F8A5E5DD31D900;
   localparam logic [63:0] WK_C  = 64'h8000000000000000;

   initial begin
      logic [63:0] rk, rb, re;

      rst = 1'b1; start = 1'b0; decrypt = 1'b0; key = '0; din = '0;
      repeat (3) @(negedge clk);
      check("reset busy", {63'd0, busy}, 64'd0);
      check("reset done", {63'd0, done}, 64'd0);
      check("reset dout", dout, 64'd0);
      rst = 1'b0;

      // known answers, then decrypt started back-to-back in cycle LAT+1
      run_op("enc_kat", KAT_K, KAT_P, 1'b0, KAT_C, 64'd0, 1'b0);
      @(negedge clk);
      run_op("dec_kat", KAT_K, KAT_C, 1'b1, KAT_P, KAT_C, 1'b0);
      idle_check("after_kat", 2, KAT_P);

      // weak key round trip
      run_op("weak_enc", WK_K, WK_P, 1'b0, WK_C, KAT_P, 1'b0);
      idle_check("weak_enc", 1, WK_C);
      run_op("weak_dec", WK_K, WK_C, 1'b1, WK_P, WK_C, 1'b0);
      idle_check("weak_dec", 1, WK_P);

      // extra starts during RUN and FIN must be ignored
      run_op("ghost", KAT_K, KAT_P, 1'b0, KAT_C, WK_P, 1'b1);
      idle_check("ghost", 4, KAT_C);

      // reset in cycle 8 together with a start: reset wins, no done follows
      key = KAT_K; din = KAT_P; decrypt = 1'b0; start = 1'b1;
      for (int cy = 1; cy <= 8; cy++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b1;
      start = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
      check("midrst busy", {63'd0, busy}, 64'd0);
      check("midrst done", {63'd0, done}, 64'd0);
      check("midrst dout", dout, 64'd0);
      idle_check("midrst", 12, 64'd0);
      run_op("post_rst", KAT_K, KAT_P, 1'b0, KAT_C, 64'd0, 1'b0);
      idle_check("post_rst", 1, KAT_C);

      // randomized blocks against the reference model
      re = KAT_C;
      for (int it = 0; it < 6; it++) begin
         rk = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         run_op($sformatf("rnd_enc%0d", it), rk, rb, 1'b0, des_ref(rk, rb, 1'b0), re, 1'b0);
         re = des_ref(rk, rb, 1'b0);
         @(negedge clk);
         run_op($sformatf("rnd_dec%0d", it), rk, re, 1'b1, rb, re, 1'b0);
         @(negedge clk);
         rb = {$urandom, $urandom};
         run_op($sformatf("rnd_raw%0d", it), rk, rb, 1'b1, des_ref(rk, rb, 1'b1), des_ref(rk, re, 1'b1), 1'b0);
         re = des_ref(rk, rb, 1'b1);
         idle_check($sformatf("rnd%0d", it), 1, re);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
